// File: rtl/uart_receiver.sv
// UART receiver for 10-bit frames (start, 7 data LSB first, even parity, stop), mid-bit sampled.
// Define UART_RX_PARITY_DROP_EN to suppress rx_valid/rx_data updates on parity errors.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int BAUD_RATE     = 9600,
    parameter int CLK_PERIOD_NS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [6:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CLKS_PER_BIT = (1000000000 / BAUD_RATE) / CLK_PERIOD_NS;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t           state, state_next;
    logic             sync_1, rx_s, rx_prev;
    logic [1:0]       sync_ok;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic             par_bit;
    logic             bit_tick, cnt_clr, accept, ferr_set, perr;

    assign bit_tick = (clk_cnt == BIT_END);
    assign perr     = (^shreg) ^ par_bit;
    assign busy     = (state != IDLE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        accept     = 1'b0;
        ferr_set   = 1'b0;
        unique case (state)
            IDLE: if (rx_prev && !rx_s) begin
                state_next = START;
                cnt_clr    = 1'b1;
            end
            START: if (clk_cnt == HALF_END) begin
                cnt_clr    = 1'b1;
                state_next = rx_s ? IDLE : DATA;
            end
            DATA: if (bit_tick) begin
                cnt_clr = 1'b1;
                if (bit_cnt == 3'd6) state_next = PARITY;
            end
            PARITY: if (bit_tick) begin
                cnt_clr    = 1'b1;
                state_next = STOP;
            end
            STOP: if (bit_tick) begin
                cnt_clr = 1'b1;
                if (rx_s) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end else begin
                    ferr_set   = 1'b1;
                    state_next = WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= 1'b1;
            rx_s       <= 1'b1;
            sync_ok    <= 2'b00;
            rx_prev    <= 1'b0;
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_1  <= serial_in;
            rx_s    <= sync_1;
            // rx_prev only reports a high line once rx_s carries real pin data, so a
            // line held low through reset never looks like a start edge.
            sync_ok <= {sync_ok[0], 1'b1};
            rx_prev <= sync_ok[1] & rx_s;
            state   <= state_next;

            if (cnt_clr || state == IDLE || state == WAIT_IDLE) clk_cnt <= '0;
            else                                                clk_cnt <= clk_cnt + 1'b1;

            if (state != DATA) bit_cnt <= '0;
            else if (bit_tick) begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {rx_s, shreg[6:1]};
            end

            if (state == PARITY && bit_tick) par_bit <= rx_s;

            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= ferr_set;
            if (accept) begin
                parity_err <= perr;
`ifdef UART_RX_PARITY_DROP_EN
                if (!perr) begin
                    rx_valid <= 1'b1;
                    rx_data  <= shreg;
                end
`else
                rx_valid <= 1'b1;
                rx_data  <= shreg;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames with a scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int HALF = 8;
    // Strobe cycle relative to the cycle the start bit is driven: 2 synchronizer cycles
    // to detection, then HALF + 9*CPB to the stop sample, then 1 for the registered strobe.
    localparam int LATENCY = 2 + HALF + 9 * CPB + 1;

    logic       clk, rst, serial_in;
    logic [6:0] rx_data;
    logic       rx_valid, parity_err, frame_err, busy;

    typedef struct {
        logic       valid;
        logic       perr;
        logic       ferr;
        logic [6:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [6:0] last_data = '0;
    logic       prev_valid = 1'b0;

    uart_receiver #(.BAUD_RATE(1250000), .CLK_PERIOD_NS(50)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .rx_data(rx_data),
        .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge ending the stop bit.
    task automatic send_frame(input logic [6:0] ch, input logic par_flip, input logic stop);
        logic [9:0] bits;
        exp_t       e;
        bits     = {stop, (^ch) ^ par_flip, ch, 1'b0};
        e.cyc    = cyc + LATENCY;
        e.data   = last_data;
        e.perr   = 1'b0;
        e.ferr   = !stop;
        e.valid  = 1'b0;
        if (stop) begin
            e.perr = par_flip;
`ifdef UART_RX_PARITY_DROP_EN
            e.valid = !par_flip;
`else
            e.valid = 1'b1;
`endif
            if (e.valid) begin
                e.data    = ch;
                last_data = ch;
            end
        end
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (rx_valid || parity_err || frame_err)) begin
            check("valid_one_cycle", {31'd0, prev_valid & rx_valid}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("rx_valid", {31'd0, rx_valid}, {31'd0, e.valid});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                check("rx_data", {25'd0, rx_data}, {25'd0, e.data});
            end
        end
        prev_valid <= rx_valid;
    end

    initial begin
        int busy_cnt;
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {27'd0, rx_data, rx_valid, parity_err, frame_err, busy}, 32'd0);
        @(posedge clk); #1;
        idle(10);

        // Clean 0x55 frame, checked for exact strobe timing by the scoreboard.
        send_frame(7'h55, 1'b0, 1'b1);
        idle(20);

        // 0x07 with the parity bit forced wrong.
        send_frame(7'h07, 1'b1, 1'b1);
        idle(20);

        // 0x12 with a low stop bit, line then held low (break) before returning high.
        send_frame(7'h12, 1'b0, 1'b0);
        serial_in = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        check("busy_during_break", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        serial_in = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("busy_after_break", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        idle(20);

        // 4-cycle low glitch on an idle line.
        busy_cnt = 0;
        serial_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 4) serial_in = 1'b1;
        end
        check("glitch_busy_cycles", busy_cnt, 32'd8);
        @(posedge clk); #1;
        idle(20);

        // Back-to-back frames, no idle gap.
        send_frame(7'h41, 1'b0, 1'b1);
        send_frame(7'h7F, 1'b0, 1'b1);
        idle(20);

        // Frame aborted by reset during data bit 3 (character 0x35 = 0110101).
        serial_in = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            serial_in = (i == 1) ? 1'b0 : 1'b1;
            repeat (CPB) @(posedge clk);
            #1;
        end
        serial_in = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        serial_in = 1'b1;
        @(negedge clk);
        check("abort_reset_outputs", {27'd0, rx_data, rx_valid, parity_err, frame_err, busy}, 32'd0);
        last_data = 7'h00;
        @(posedge clk); #1;
        idle(40);
        send_frame(7'h2A, 1'b0, 1'b1);
        idle(30);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
